// File: rtl/shreg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// shreg_ctrl_pkg : shared types and constants for the shift-register sequencer
// Revision: 1.0
// ============================================================================
package shreg_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_e;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shreg_ctrl_cnt.sv
`default_nettype none
// ============================================================================
// shreg_ctrl_cnt : shift-bit counter with clear, enable and last-bit flag
// Revision: 1.0
// ============================================================================
module shreg_ctrl_cnt
    import shreg_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last
);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == CW'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/shreg_ctrl.sv
`default_nettype none
// ============================================================================
// shreg_ctrl : loads a parallel word, shifts it MSB-first into a SHREG and
//              returns the SHREG readback. Optional macro SHREG_CTRL_VERIFY_EN
//              adds a readback comparator driving ERR.
// Revision: 1.0
// ============================================================================
module shreg_ctrl
    import shreg_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_DATA,
    output logic             SH_CLR,
    output logic             SH_EN,
    output logic             SH_D,
    input  logic [WIDTH-1:0] SH_Q,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             ERR
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] word_rev;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             sh_clr_q, sh_clr_d;
    logic             sh_en_q, sh_en_d;
    logic             sh_d_q, sh_d_d;
    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    idx_nxt;
    logic             cnt_last;

    shreg_ctrl_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk   (CLK),
        .rst_n (CLR_N),
        .clr   (state_q == CLEAR),
        .en    ((state_q == SHIFT) && !cnt_last),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    // Bit-reversed copy so the counter indexes MSB-first directly.
    always_comb begin
        word_rev = '0;
        for (int i = 0; i < WIDTH; i++) begin
            word_rev[i] = word_q[WIDTH-1-i];
        end
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    word_d  = IN_DATA;
                    state_d = CLEAR;
                end
            end
            CLEAR:   state_d = SHIFT;
            SHIFT:   if (cnt_last) state_d = CAPTURE;
            CAPTURE: begin
                out_data_d = SH_Q;
                state_d    = DONE;
            end
            DONE:    if (OUT_READY) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        idx_nxt     = (state_q == SHIFT) ? cnt + CW'(1) : '0;
        sh_clr_d    = (state_d == CLEAR);
        sh_en_d     = (state_d == SHIFT);
        sh_d_d      = sh_en_d & word_rev[idx_nxt];
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q     <= IDLE;
            word_q      <= '0;
            out_data_q  <= '0;
            sh_clr_q    <= 1'b0;
            sh_en_q     <= 1'b0;
            sh_d_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            out_data_q  <= out_data_d;
            sh_clr_q    <= sh_clr_d;
            sh_en_q     <= sh_en_d;
            sh_d_q      <= sh_d_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SHREG_CTRL_VERIFY_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((state_q == IDLE) && IN_VALID) begin
            err_d = 1'b0;
        end else if (state_q == CAPTURE) begin
            err_d = (SH_Q != word_q);
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign IN_READY  = (state_q == IDLE);
    assign SH_CLR    = sh_clr_q;
    assign SH_EN     = sh_en_q;
    assign SH_D      = sh_d_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_shreg_ctrl.sv
`default_nettype none
// ============================================================================
// tb_shreg_ctrl : directed bench for shreg_ctrl (WIDTH=4 and WIDTH=8) with
//                 behavioural SHREG models
// Revision: 1.0
// ============================================================================
module tb_shreg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    int         checks   = 0;
    int         failures = 0;

    // WIDTH=4 instance
    logic       in_valid, in_ready, sh_clr, sh_en, sh_d, out_valid, out_ready, err;
    logic [3:0] in_data, sh_q, out_data, shreg, stuck_mask, bits4;

    // WIDTH=8 instance
    logic       in_valid8, in_ready8, sh_clr8, sh_en8, sh_d8, out_valid8, out_ready8, err8;
    logic [7:0] in_data8, sh_q8, out_data8, shreg8, bits8;

    logic       exp_err;

    always #5 clk = ~clk;

    shreg_ctrl #(.WIDTH(4)) dut4 (
        .CLK(clk), .CLR_N(rst_n),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data),
        .SH_CLR(sh_clr), .SH_EN(sh_en), .SH_D(sh_d), .SH_Q(sh_q),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
        .ERR(err)
    );

    shreg_ctrl #(.WIDTH(8)) dut8 (
        .CLK(clk), .CLR_N(rst_n),
        .IN_VALID(in_valid8), .IN_READY(in_ready8), .IN_DATA(in_data8),
        .SH_CLR(sh_clr8), .SH_EN(sh_en8), .SH_D(sh_d8), .SH_Q(sh_q8),
        .OUT_VALID(out_valid8), .OUT_READY(out_ready8), .OUT_DATA(out_data8),
        .ERR(err8)
    );

    // Behavioural SHREGs; the 4-bit one can have stuck-at-0 bits.
    always_ff @(posedge clk) begin
        if (sh_clr)      shreg <= '0;
        else if (sh_en)  shreg <= {shreg[2:0], sh_d};
        if (sh_clr8)     shreg8 <= '0;
        else if (sh_en8) shreg8 <= {shreg8[6:0], sh_d8};
    end
    assign sh_q  = shreg & ~stuck_mask;
    assign sh_q8 = shreg8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef SHREG_CTRL_VERIFY_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst_n = 1'b0; in_valid = 0; in_data = '0; out_ready = 0; stuck_mask = '0;
        in_valid8 = 0; in_data8 = '0; out_ready8 = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sh_clr", sh_clr, 0);
        chk("rst_sh_en", sh_en, 0);
        chk("rst_sh_d", sh_d, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_err", err, 0);
        chk("rst8_in_ready", in_ready8, 1);

        // Basic transaction 1011, consumer always ready
        in_valid = 1; in_data = 4'b1011; out_ready = 1; bits4 = 4'b1011;
        @(negedge clk);                                   // cycle 1
        in_valid = 0;
        chk("t1_sh_clr", sh_clr, 1);
        chk("t1_in_ready_busy", in_ready, 0);
        chk("t1_sh_en_clear", sh_en, 0);
        for (int k = 0; k < 4; k++) begin                 // cycles 2..5
            @(negedge clk);
            chk("t1_sh_en", sh_en, 1);
            chk("t1_sh_d", sh_d, bits4[3-k]);
            chk("t1_sh_clr_shift", sh_clr, 0);
        end
        @(negedge clk);                                   // cycle 6
        chk("t1_sh_en_capture", sh_en, 0);
        chk("t1_out_valid_early", out_valid, 0);
        @(negedge clk);                                   // cycle 7
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_data", out_data, 4'b1011);
        chk("t1_err", err, 0);
        @(negedge clk);                                   // cycle 8
        chk("t1_out_valid_fall", out_valid, 0);
        chk("t1_in_ready_back", in_ready, 1);

        // Back-to-back with IN_VALID held high: F then 0
        in_valid = 1; in_data = 4'hF;
        @(negedge clk);                                   // cycle 1
        chk("t3_sh_clr", sh_clr, 1);
        in_data = 4'h0;
        repeat (6) @(negedge clk);                        // cycle 7
        chk("t3_out_valid_a", out_valid, 1);
        chk("t3_out_data_a", out_data, 4'hF);
        @(negedge clk);                                   // cycle 8
        chk("t3_in_ready_8", in_ready, 1);
        chk("t3_out_valid_8", out_valid, 0);
        @(negedge clk);                                   // cycle 9
        chk("t3_second_accept", sh_clr, 1);
        chk("t3_in_ready_9", in_ready, 0);
        in_valid = 0;
        repeat (6) @(negedge clk);                        // cycle 15
        chk("t3_out_valid_b", out_valid, 1);
        chk("t3_out_data_b", out_data, 4'h0);
        @(negedge clk);
        chk("t3_idle", in_ready, 1);

        // Consumer stalls 5 cycles in DONE
        in_valid = 1; in_data = 4'b0101; out_ready = 0;
        @(negedge clk);                                   // cycle 1
        in_valid = 0;
        repeat (6) @(negedge clk);                        // cycle 7
        for (int k = 0; k < 5; k++) begin                 // cycles 7..11
            chk("t2_hold_valid", out_valid, 1);
            chk("t2_hold_data", out_data, 4'b0101);
            chk("t2_hold_in_ready", in_ready, 0);
            if (k < 4) @(negedge clk);
        end
        out_ready = 1;
        @(negedge clk);                                   // cycle 12
        chk("t2_release_valid", out_valid, 0);
        chk("t2_release_in_ready", in_ready, 1);

        // Asynchronous reset during the third SHIFT cycle
        in_valid = 1; in_data = 4'b1010;
        @(negedge clk);                                   // cycle 1
        in_valid = 0;
        repeat (3) @(negedge clk);                        // cycle 4
        chk("t4_shifting", sh_en, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t4_rst_sh_en", sh_en, 0);
        chk("t4_rst_sh_d", sh_d, 0);
        chk("t4_rst_sh_clr", sh_clr, 0);
        chk("t4_rst_out_valid", out_valid, 0);
        chk("t4_rst_out_data", out_data, 0);
        chk("t4_rst_in_ready", in_ready, 1);
        chk("t4_rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t4_no_out_valid", out_valid, 0);
        end
        in_valid = 1; in_data = 4'h6;
        @(negedge clk);
        in_valid = 0;
        repeat (6) @(negedge clk);                        // cycle 7
        chk("t4_next_valid", out_valid, 1);
        chk("t4_next_data", out_data, 4'h6);
        @(negedge clk);

        // Stuck-at-0 on Q[2]
        stuck_mask = 4'b0100;
        in_valid = 1; in_data = 4'b0110;
        @(negedge clk);
        in_valid = 0;
        repeat (6) @(negedge clk);                        // cycle 7
        chk("t5_out_data", out_data, 4'b0010);
        chk("t5_err", err, exp_err);
        @(negedge clk);                                   // cycle 8
        chk("t5_err_sticky", err, exp_err);
        stuck_mask = 4'b0000;
        in_valid = 1; in_data = 4'b1001;
        @(negedge clk);                                   // cycle 1
        in_valid = 0;
        chk("t5_err_cleared", err, 0);
        repeat (6) @(negedge clk);                        // cycle 7
        chk("t5_next_data", out_data, 4'b1001);
        chk("t5_next_err", err, 0);
        @(negedge clk);

        // WIDTH=8 instance with A5
        bits8 = 8'hA5;
        in_valid8 = 1; in_data8 = 8'hA5; out_ready8 = 1;
        @(negedge clk);                                   // cycle 1
        in_valid8 = 0;
        chk("t6_sh_clr", sh_clr8, 1);
        for (int k = 0; k < 8; k++) begin                 // cycles 2..9
            @(negedge clk);
            chk("t6_sh_en", sh_en8, 1);
            chk("t6_sh_d", sh_d8, bits8[7-k]);
        end
        @(negedge clk);                                   // cycle 10
        chk("t6_sh_en_capture", sh_en8, 0);
        chk("t6_out_valid_early", out_valid8, 0);
        @(negedge clk);                                   // cycle 11
        chk("t6_out_valid", out_valid8, 1);
        chk("t6_out_data", out_data8, 8'hA5);
        chk("t6_err", err8, 0);
        @(negedge clk);
        chk("t6_idle", in_ready8, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shreg_ctrl.md
# shreg_ctrl

Sequencer for the 4-bit serial-in/parallel-out shift register (SHREG_4bit family). It accepts a parallel word over a valid/ready handshake, clears the shift register, then shifts the word in serially, MSB first. It reads back the parallel output and presents it as a result over a second valid/ready handshake. It sits between a parallel producer and the SHREG instance and owns that instance's clear, shift-enable and serial-data inputs.

## Interface
- WIDTH, default 4: shift register length and data word width; must be ≥2.
- CLK  in  1  rising-edge clock, shared with the SHREG instance.
- CLR_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  producer has a word on IN_DATA.
- IN_READY  out  1  controller can accept a word; high only in IDLE.
- IN_DATA  in  WIDTH  word to serialise.
- SH_CLR  out  1  active-high clear to SHREG.
- SH_EN  out  1  shift enable to SHREG; SHREG does Q <= {Q[WIDTH-2:0], D} on an edge with SH_EN=1.
- SH_D  out  1  serial data to SHREG.
- SH_Q  in  WIDTH  SHREG parallel output.
- OUT_VALID  out  1  result available on OUT_DATA.
- OUT_READY  in  1  consumer accepts the result.
- OUT_DATA  out  WIDTH  captured SH_Q.
- ERR  out  1  readback mismatch flag; depends on the SHREG_CTRL_VERIFY_EN configuration.

## Operation
- States:
  - IDLE: IN_READY=1; IN_VALID & IN_READY latches IN_DATA into word_r, then go to CLEAR.
  - CLEAR: SH_CLR=1 for one cycle, then SHIFT with cnt=0.
  - SHIFT: SH_EN=1, SH_D=word_r[WIDTH-1-cnt]; cnt increments each cycle; after the cycle with cnt=WIDTH-1, go to CAPTURE.
  - CAPTURE: SH_EN=0; latch SH_Q into OUT_DATA register; go to DONE.
  - DONE: OUT_VALID=1; hold OUT_DATA stable until OUT_READY=1, then go to IDLE.
- SH_CLR, SH_EN, SH_D, OUT_VALID and OUT_DATA are registered; no output is combinational from IN_* or OUT_READY.
- IN_READY is decoded from the state register.
- IN_VALID outside IDLE is ignored. No word is buffered, and acceptance is not overlapped with DONE.
- cnt is clog2(WIDTH) bits and is compared against WIDTH-1; it never wraps within a transaction.
- SH_D=0 and SH_EN=0 outside SHIFT. SH_CLR=0 outside CLEAR.
- Reset (CLR_N low), asynchronous at any point including mid-SHIFT:
  - state=IDLE, cnt=0, word_r=0, OUT_DATA=0, ERR=0.
  - SH_CLR=0, SH_EN=0, SH_D=0, OUT_VALID=0, IN_READY=1.
  - An aborted transaction is discarded; no OUT_VALID is produced for it.

## Timing
- Acceptance edge E0 → CLEAR during cycle 1 → SHIFT during cycles 2..WIDTH+1 → CAPTURE during cycle WIDTH+2 → OUT_VALID from cycle WIDTH+3.
- With WIDTH=4, OUT_VALID first rises in cycle 7.
- Output handshake completes on the edge where OUT_VALID & OUT_READY. OUT_VALID falls and IN_READY rises in the next cycle.
- Minimum spacing between acceptances is WIDTH+4 cycles (8 for WIDTH=4).
- OUT_READY held high before DONE: completion occurs in the first DONE cycle.

## Configuration
- SHREG_CTRL_VERIFY_EN defined:
  - In CAPTURE, compare SH_Q against word_r.
  - On mismatch, ERR=1 at the same edge OUT_VALID rises.
  - ERR is sticky until the next acceptance edge, which clears it, or until reset.
- Not defined: ERR tied to 0; no comparator is compiled.

## Structure
- shreg_ctrl_pkg holds:
  - the state enum (IDLE, CLEAR, SHIFT, CAPTURE, DONE);
  - the default WIDTH constant;
  - a function computing the counter width from WIDTH.
- One sub-module, shreg_ctrl_cnt: shift-bit counter with clear, enable and last-bit flag (cnt==WIDTH-1). It is instantiated once, with reset tied to CLR_N.

## Test plan
- Reset release, IN_DATA=4'b1011, IN_VALID=1, OUT_READY=1 with a behavioural SHREG:
  - SH_D sequence 1,0,1,1 during cycles 2–5;
  - OUT_VALID in cycle 7 with OUT_DATA=4'b1011;
  - ERR=0.
- OUT_READY held low 5 cycles in DONE → OUT_VALID and OUT_DATA stable throughout; IN_READY=0 until the cycle after OUT_READY rises.
- IN_VALID held high continuously with 4'hF then 4'h0 → second acceptance exactly 8 cycles after the first; OUT_DATA 4'hF then 4'h0.
- CLR_N pulsed low during the third SHIFT cycle:
  - all outputs reach their reset values immediately;
  - no OUT_VALID appears;
  - the next word 4'h6 completes normally.
- With SHREG_CTRL_VERIFY_EN defined, SHREG model stuck-at-0 on Q[2], word 4'b0110:
  - OUT_DATA=4'b0010 and ERR=1;
  - next word 4'b1001 clears ERR at its acceptance edge.
- WIDTH=8, word 8'hA5 → eight SH_EN cycles; OUT_VALID in cycle 11 with OUT_DATA=8'hA5.
